ifu_pcgen_ctrl: RTL and testbench
=================================

IFU_PCGEN_CTRL -- requirements
Module: ifu_pcgen_ctrl

Interface
REQ-001 SHALL have parameter PC_SIZE, default 32: width of all PC and address operands.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-004 SHALL have port pc_rtvec, input, PC_SIZE: reset vector, sampled when leaving RESET.
REQ-005 SHALL have ports ifu_req_valid (output, 1), ifu_req_ready (input, 1) and ifu_req_pc (output, PC_SIZE): fetch request channel.
REQ-006 SHALL have ports ifu_rsp_valid (input, 1) and ifu_rsp_ready (output, 1): returned, mini-decoded instruction.
REQ-007 SHALL have port dec_rv32, input, 1: returned instruction is 32-bit when 1, 16-bit when 0.
REQ-008 SHALL have ports prdt_taken (input, 1), prdt_pc_add_op1 and prdt_pc_add_op2 (input, PC_SIZE each), and bpu_wait (input, 1): BPU results.
REQ-009 SHALL have port pc_r, output, PC_SIZE: PC of the outstanding instruction, driven to the BPU.
REQ-010 SHALL have ports pipe_flush_req (input, 1), pipe_flush_ack (output, 1) and pipe_flush_pc (input, PC_SIZE): EXU redirect.
REQ-011 SHALL have ports halt_req (input, 1) and halt_ack (output, 1): debug/WFI halt.

Function
REQ-012 SHALL implement the FSM states RESET, ISSUE, WAIT_RSP and HALTED, with at most one request outstanding.
REQ-013 RESET SHALL last exactly one cycle after rst_n deasserts, then enter ISSUE with req_pc_r = pc_rtvec.
REQ-014 In ISSUE: ifu_req_valid=1 and ifu_req_pc=req_pc_r, held stable until accepted; on valid&ready, pc_r<=req_pc_r and the FSM enters WAIT_RSP.
REQ-015 ifu_rsp_ready SHALL be 1 only in WAIT_RSP, and be gated by ~bpu_wait unless a flush is pending; responses in any other state are ignored.
REQ-016 On response accept (WAIT_RSP, rsp_valid&rsp_ready), next PC SHALL be selected by priority: pending flush -> flush_pc_r; prdt_taken -> op1+op2; else pc_r+4 when dec_rv32, pc_r+2 otherwise.
REQ-017 SHALL use exactly one PC_SIZE-bit adder shared by the taken and sequential cases; its result wraps modulo 2^PC_SIZE and bit 0 is forced to 0.
REQ-018 pipe_flush_ack SHALL equal pipe_flush_req & ~flush_pend_r (same cycle); on ack, flush_pend_r<=1 and flush_pc_r<=pipe_flush_pc.
REQ-019 A response accepted while a flush is pending SHALL be discarded (BPU inputs ignored); flush_pend_r clears on that same edge.
REQ-020 A flush acked while in ISSUE SHALL NOT alter ifu_req_pc; the in-flight request completes and its response is discarded per REQ-019.
REQ-021 A flush acked while in HALTED SHALL load req_pc_r from flush_pc_r on the next edge and clear flush_pend_r.
REQ-022 A new pipe_flush_req arriving while flush_pend_r=1 SHALL NOT be acked until the pending flush clears.
REQ-023 Wrap-around: pc_r=0xFFFF_FFFE with a 16-bit sequential instruction SHALL yield next PC 0x0000_0000.

Reset
REQ-024 While rst_n=0: state=RESET, ifu_req_valid=0, ifu_rsp_ready=0, pc_r=0, req_pc_r=0, flush_pend_r=0, flush_pc_r=0, halt_ack=0, pipe_flush_ack=0.
REQ-025 Reset asserted mid-transaction SHALL abandon the outstanding request without waiting for its response.

Configuration
REQ-026 With macro IFU_PCGEN_HALT_EN defined: on response accept with halt_req=1, next PC goes to req_pc_r and the FSM enters HALTED; halt_ack=1 in HALTED; on halt_req=0 the FSM returns to ISSUE.
REQ-027 Without IFU_PCGEN_HALT_EN: HALTED does not exist, halt_req is ignored and halt_ack is tied to 0.

Verification
REQ-028 Reset release with pc_rtvec=0x8000_0000 and ready=1 -> cycle 2 ifu_req_pc=0x8000_0000; after an rv32 not-taken response -> next request 0x8000_0004.
REQ-029 Response with prdt_taken=1, op1=0x8000_0010, op2=0xFFFF_FFF0 -> next request 0x8000_0000.
REQ-030 bpu_wait=1 for 3 cycles while rsp_valid=1 -> rsp_ready=0 for those 3 cycles, no new request, pc_r stable.
REQ-031 Flush to 0x8000_0100 while in WAIT_RSP with prdt_taken=1 -> ack in the same cycle, response discarded, next request 0x8000_0100.
REQ-032 Flush held while ifu_req_ready=0 in ISSUE -> ifu_req_pc unchanged; a second flush is not acked until the first resolves.
REQ-033 With IFU_PCGEN_HALT_EN: halt_req=1 during a 16-bit response at 0x8000_0002 -> HALTED, halt_ack=1; halt_req=0 -> request 0x8000_0004.

Source files
------------

// File: rtl/ifu_pcgen_ctrl.sv
// ifu_pcgen_ctrl: fetch PC generation for the instruction fetch unit.
// Keeps at most one fetch request outstanding, computes the next PC from the
// mini-decoded response (sequential or BPU-predicted) and handles EXU
// redirects (flushes).
// Optional debug/WFI halt support is enabled by defining IFU_PCGEN_HALT_EN;
// without it halt_req is ignored and halt_ack is tied low.
module ifu_pcgen_ctrl #(
  parameter int PC_SIZE = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [PC_SIZE-1:0] pc_rtvec,
  output logic               ifu_req_valid,
  input  logic               ifu_req_ready,
  output logic [PC_SIZE-1:0] ifu_req_pc,
  input  logic               ifu_rsp_valid,
  output logic               ifu_rsp_ready,
  input  logic               dec_rv32,
  input  logic               prdt_taken,
  input  logic [PC_SIZE-1:0] prdt_pc_add_op1,
  input  logic [PC_SIZE-1:0] prdt_pc_add_op2,
  input  logic               bpu_wait,
  output logic [PC_SIZE-1:0] pc_r,
  input  logic               pipe_flush_req,
  output logic               pipe_flush_ack,
  input  logic [PC_SIZE-1:0] pipe_flush_pc,
  input  logic               halt_req,
  output logic               halt_ack
);

  typedef enum logic [1:0] {
    ST_RESET    = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_WAIT_RSP = 2'd2
`ifdef IFU_PCGEN_HALT_EN
    ,
    ST_HALTED   = 2'd3
`endif
  } state_e;

  state_e             state_q, state_d;
  logic [PC_SIZE-1:0] req_pc_q, req_pc_d;
  logic [PC_SIZE-1:0] pc_q, pc_d;
  logic               flush_pend_q, flush_pend_d;
  logic [PC_SIZE-1:0] flush_pc_q, flush_pc_d;

  logic               flush_ack_s;
  logic               flush_eff_s;
  logic [PC_SIZE-1:0] flush_tgt_s;
  logic               rsp_acc_s;
  logic [PC_SIZE-1:0] add_a_s;
  logic [PC_SIZE-1:0] add_b_s;
  logic [PC_SIZE-1:0] add_sum_s;
  logic [PC_SIZE-1:0] add_res_s;

  // Flush handshake, response handshake and the single shared next-PC adder.
  always_comb begin
    flush_ack_s = pipe_flush_req & ~flush_pend_q & (state_q != ST_RESET);
    // A flush acked in the same cycle as a response is treated as pending.
    flush_eff_s = flush_pend_q | flush_ack_s;
    flush_tgt_s = flush_pend_q ? flush_pc_q : pipe_flush_pc;
    ifu_rsp_ready = (state_q == ST_WAIT_RSP) & (flush_pend_q | ~bpu_wait);
    rsp_acc_s   = ifu_rsp_valid & ifu_rsp_ready;
    add_a_s     = prdt_taken ? prdt_pc_add_op1 : pc_q;
    add_b_s     = prdt_taken ? prdt_pc_add_op2
                             : (dec_rv32 ? PC_SIZE'(32'd4) : PC_SIZE'(32'd2));
    add_sum_s   = add_a_s + add_b_s;
    add_res_s   = {add_sum_s[PC_SIZE-1:1], 1'b0};
  end

  // Next-state logic for the FSM and the PC/flush bookkeeping registers.
  always_comb begin
    state_d      = state_q;
    req_pc_d     = req_pc_q;
    pc_d         = pc_q;
    flush_pend_d = flush_pend_q;
    flush_pc_d   = flush_pc_q;
    if (flush_ack_s) begin
      flush_pend_d = 1'b1;
      flush_pc_d   = pipe_flush_pc;
    end else begin
      flush_pend_d = flush_pend_q;
      flush_pc_d   = flush_pc_q;
    end
    case (state_q)
      ST_RESET: begin
        state_d  = ST_ISSUE;
        req_pc_d = pc_rtvec;
      end
      ST_ISSUE: begin
        if (ifu_req_ready) begin
          pc_d    = req_pc_q;
          state_d = ST_WAIT_RSP;
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_WAIT_RSP: begin
        if (rsp_acc_s) begin
          // A pending redirect discards the response and its BPU result.
          req_pc_d     = flush_eff_s ? flush_tgt_s : add_res_s;
          flush_pend_d = 1'b0;
`ifdef IFU_PCGEN_HALT_EN
          state_d      = halt_req ? ST_HALTED : ST_ISSUE;
`else
          state_d      = ST_ISSUE;
`endif
        end else begin
          state_d = ST_WAIT_RSP;
        end
      end
`ifdef IFU_PCGEN_HALT_EN
      ST_HALTED: begin
        if (flush_pend_q) begin
          req_pc_d     = flush_pc_q;
          flush_pend_d = 1'b0;
        end else begin
          req_pc_d = req_pc_q;
        end
        if (!halt_req) begin
          state_d = ST_ISSUE;
        end else begin
          state_d = ST_HALTED;
        end
      end
`endif
      default: begin
        state_d = ST_RESET;
      end
    endcase
  end

  // State and PC registers; reset abandons any outstanding request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_RESET;
      req_pc_q     <= '0;
      pc_q         <= '0;
      flush_pend_q <= 1'b0;
      flush_pc_q   <= '0;
    end else begin
      state_q      <= state_d;
      req_pc_q     <= req_pc_d;
      pc_q         <= pc_d;
      flush_pend_q <= flush_pend_d;
      flush_pc_q   <= flush_pc_d;
    end
  end

  assign ifu_req_valid  = (state_q == ST_ISSUE);
  assign ifu_req_pc     = req_pc_q;
  assign pc_r           = pc_q;
  assign pipe_flush_ack = flush_ack_s;

`ifdef IFU_PCGEN_HALT_EN
  assign halt_ack = (state_q == ST_HALTED);
`else
  logic unused_halt_req_s;
  assign unused_halt_req_s = halt_req;
  assign halt_ack = 1'b0;
`endif

endmodule

// File: tb/tb_ifu_pcgen_ctrl.sv
// Directed, table-driven bench for ifu_pcgen_ctrl (PC_SIZE = 32).
module tb_ifu_pcgen_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_rtvec;
  logic        ifu_req_valid;
  logic        ifu_req_ready;
  logic [31:0] ifu_req_pc;
  logic        ifu_rsp_valid;
  logic        ifu_rsp_ready;
  logic        dec_rv32;
  logic        prdt_taken;
  logic [31:0] prdt_pc_add_op1;
  logic [31:0] prdt_pc_add_op2;
  logic        bpu_wait;
  logic [31:0] pc_r;
  logic        pipe_flush_req;
  logic        pipe_flush_ack;
  logic [31:0] pipe_flush_pc;
  logic        halt_req;
  logic        halt_ack;

  int checks = 0;
  int errors = 0;

  ifu_pcgen_ctrl #(.PC_SIZE(32)) dut (
    .clk(clk), .rst_n(rst_n), .pc_rtvec(pc_rtvec),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
    .ifu_req_pc(ifu_req_pc), .ifu_rsp_valid(ifu_rsp_valid),
    .ifu_rsp_ready(ifu_rsp_ready), .dec_rv32(dec_rv32),
    .prdt_taken(prdt_taken), .prdt_pc_add_op1(prdt_pc_add_op1),
    .prdt_pc_add_op2(prdt_pc_add_op2), .bpu_wait(bpu_wait), .pc_r(pc_r),
    .pipe_flush_req(pipe_flush_req), .pipe_flush_ack(pipe_flush_ack),
    .pipe_flush_pc(pipe_flush_pc), .halt_req(halt_req), .halt_ack(halt_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] rtvec;
    logic        rv32;
    logic        taken;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] exp_next;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_rsp();
    ifu_rsp_valid   = 1'b0;
    dec_rv32        = 1'b0;
    prdt_taken      = 1'b0;
    prdt_pc_add_op1 = 32'h0;
    prdt_pc_add_op2 = 32'h0;
    bpu_wait        = 1'b0;
  endtask

  // Reset, check reset values, release; returns in the first ISSUE cycle.
  task automatic do_reset(input logic [31:0] rtvec);
    rst_n = 1'b0;
    clear_rsp();
    ifu_req_ready  = 1'b0;
    pipe_flush_req = 1'b0;
    pipe_flush_pc  = 32'h0;
    halt_req       = 1'b0;
    pc_rtvec       = rtvec;
    step();
    @(negedge clk);
    chk("rst_req_valid", {31'd0, ifu_req_valid}, 32'd0);
    chk("rst_rsp_ready", {31'd0, ifu_rsp_ready}, 32'd0);
    chk("rst_pc_r", pc_r, 32'h0);
    chk("rst_req_pc", ifu_req_pc, 32'h0);
    chk("rst_halt_ack", {31'd0, halt_ack}, 32'd0);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_cycle_valid", {31'd0, ifu_req_valid}, 32'd0);
    step();
  endtask

  task automatic issue_accept(input logic [31:0] exp_pc);
    ifu_req_ready = 1'b1;
    @(negedge clk);
    chk("issue_valid", {31'd0, ifu_req_valid}, 32'd1);
    chk("issue_pc", ifu_req_pc, exp_pc);
    step();
    ifu_req_ready = 1'b0;
  endtask

  task automatic respond(input logic rv32, input logic taken,
                         input logic [31:0] op1, input logic [31:0] op2);
    ifu_rsp_valid   = 1'b1;
    dec_rv32        = rv32;
    prdt_taken      = taken;
    prdt_pc_add_op1 = op1;
    prdt_pc_add_op2 = op2;
    @(negedge clk);
    chk("rsp_ready", {31'd0, ifu_rsp_ready}, 32'd1);
    step();
    clear_rsp();
  endtask

  task automatic check_next(input string name, input logic [31:0] exp_pc);
    @(negedge clk);
    chk({name, "_valid"}, {31'd0, ifu_req_valid}, 32'd1);
    chk(name, ifu_req_pc, exp_pc);
    step();
  endtask

  initial begin
    vecs[0] = '{"seq_rv32",    32'h8000_0000, 1'b1, 1'b0, 32'h0,         32'h0,         32'h8000_0004};
    vecs[1] = '{"seq_rv16",    32'h8000_0000, 1'b0, 1'b0, 32'h0,         32'h0,         32'h8000_0002};
    vecs[2] = '{"taken_neg",   32'h8000_0004, 1'b1, 1'b1, 32'h8000_0010, 32'hFFFF_FFF0, 32'h8000_0000};
    vecs[3] = '{"wrap_rv16",   32'hFFFF_FFFE, 1'b0, 1'b0, 32'h0,         32'h0,         32'h0000_0000};
    vecs[4] = '{"wrap_rv32",   32'hFFFF_FFFC, 1'b1, 1'b0, 32'h0,         32'h0,         32'h0000_0000};
    vecs[5] = '{"taken_bit0",  32'h0000_0200, 1'b0, 1'b1, 32'h0000_1001, 32'h0000_0000, 32'h0000_1000};
    vecs[6] = '{"taken_rv32",  32'h0000_0300, 1'b1, 1'b1, 32'h0000_0100, 32'h0000_0020, 32'h0000_0120};

    // Next-PC selection table.
    for (int i = 0; i < 7; i++) begin
      do_reset(vecs[i].rtvec);
      issue_accept(vecs[i].rtvec);
      @(negedge clk);
      chk({vecs[i].name, "_pc_r"}, pc_r, vecs[i].rtvec);
      step();
      respond(vecs[i].rv32, vecs[i].taken, vecs[i].op1, vecs[i].op2);
      check_next(vecs[i].name, vecs[i].exp_next);
    end

    // Responses outside WAIT_RSP are ignored; bpu_wait stalls the response.
    do_reset(32'h8000_0000);
    ifu_rsp_valid = 1'b1;
    @(negedge clk);
    chk("issue_rsp_ready", {31'd0, ifu_rsp_ready}, 32'd0);
    step();
    ifu_rsp_valid = 1'b0;
    issue_accept(32'h8000_0000);
    ifu_rsp_valid = 1'b1;
    dec_rv32      = 1'b1;
    bpu_wait      = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("bpu_wait_rsp_ready", {31'd0, ifu_rsp_ready}, 32'd0);
      chk("bpu_wait_no_req", {31'd0, ifu_req_valid}, 32'd0);
      chk("bpu_wait_pc_r", pc_r, 32'h8000_0000);
      step();
    end
    bpu_wait = 1'b0;
    @(negedge clk);
    chk("bpu_release_rsp_ready", {31'd0, ifu_rsp_ready}, 32'd1);
    step();
    clear_rsp();
    check_next("after_bpu_wait", 32'h8000_0004);

    // Flush in WAIT_RSP together with a taken response.
    issue_accept(32'h8000_0004);
    ifu_rsp_valid   = 1'b1;
    prdt_taken      = 1'b1;
    prdt_pc_add_op1 = 32'h8000_0010;
    prdt_pc_add_op2 = 32'hFFFF_FFF0;
    pipe_flush_req  = 1'b1;
    pipe_flush_pc   = 32'h8000_0100;
    @(negedge clk);
    chk("wait_flush_ack", {31'd0, pipe_flush_ack}, 32'd1);
    chk("wait_flush_rsp_ready", {31'd0, ifu_rsp_ready}, 32'd1);
    step();
    clear_rsp();
    pipe_flush_req = 1'b0;
    check_next("wait_flush_target", 32'h8000_0100);

    // Flush in ISSUE with ready low, then a second flush held behind it.
    pipe_flush_req = 1'b1;
    pipe_flush_pc  = 32'h8000_0200;
    @(negedge clk);
    chk("issue_flush_ack", {31'd0, pipe_flush_ack}, 32'd1);
    chk("issue_flush_pc_kept", ifu_req_pc, 32'h8000_0100);
    step();
    pipe_flush_pc = 32'h8000_0300;
    @(negedge clk);
    chk("second_flush_no_ack", {31'd0, pipe_flush_ack}, 32'd0);
    chk("issue_flush_pc_kept2", ifu_req_pc, 32'h8000_0100);
    step();
    issue_accept(32'h8000_0100);
    ifu_rsp_valid = 1'b1;
    dec_rv32      = 1'b1;
    bpu_wait      = 1'b1;
    @(negedge clk);
    chk("pend_rsp_ready_bypass", {31'd0, ifu_rsp_ready}, 32'd1);
    chk("second_flush_no_ack_wait", {31'd0, pipe_flush_ack}, 32'd0);
    step();
    clear_rsp();
    @(negedge clk);
    chk("first_flush_target", ifu_req_pc, 32'h8000_0200);
    chk("second_flush_ack", {31'd0, pipe_flush_ack}, 32'd1);
    step();
    pipe_flush_req = 1'b0;
    issue_accept(32'h8000_0200);
    respond(1'b1, 1'b0, 32'h0, 32'h0);
    check_next("second_flush_target", 32'h8000_0300);

    // Reset asserted in WAIT_RSP abandons the outstanding request.
    issue_accept(32'h8000_0300);
    rst_n          = 1'b0;
    pipe_flush_req = 1'b1;
    #1;
    chk("midrst_req_valid", {31'd0, ifu_req_valid}, 32'd0);
    chk("midrst_rsp_ready", {31'd0, ifu_rsp_ready}, 32'd0);
    chk("midrst_pc_r", pc_r, 32'h0);
    chk("midrst_flush_ack", {31'd0, pipe_flush_ack}, 32'd0);
    do_reset(32'h0000_4000);
    issue_accept(32'h0000_4000);
    respond(1'b0, 1'b0, 32'h0, 32'h0);
    check_next("after_midrst", 32'h0000_4002);

`ifdef IFU_PCGEN_HALT_EN
    // Halt on a 16-bit response, then resume sequentially.
    do_reset(32'h8000_0002);
    issue_accept(32'h8000_0002);
    halt_req = 1'b1;
    respond(1'b0, 1'b0, 32'h0, 32'h0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("halted_ack", {31'd0, halt_ack}, 32'd1);
      chk("halted_no_req", {31'd0, ifu_req_valid}, 32'd0);
      step();
    end
    halt_req = 1'b0;
    step();
    check_next("halt_resume", 32'h8000_0004);
    // Flush while halted redirects the resume PC.
    issue_accept(32'h8000_0004);
    halt_req = 1'b1;
    respond(1'b1, 1'b0, 32'h0, 32'h0);
    pipe_flush_req = 1'b1;
    pipe_flush_pc  = 32'h8000_0400;
    @(negedge clk);
    chk("halted_flush_ack", {31'd0, pipe_flush_ack}, 32'd1);
    step();
    pipe_flush_req = 1'b0;
    step();
    halt_req = 1'b0;
    step();
    check_next("halt_flush_resume", 32'h8000_0400);
`else
    // Without halt support halt_req has no effect.
    do_reset(32'h8000_0002);
    issue_accept(32'h8000_0002);
    halt_req = 1'b1;
    respond(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("nohalt_ack", {31'd0, halt_ack}, 32'd0);
    step();
    halt_req = 1'b0;
    check_next("nohalt_next", 32'h8000_0004);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
